// File: rtl/cam_front_pkg.sv
// Shared types for the CAM request sequencer: request opcodes and CAM command encoding.
package cam_front_pkg;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        INSERT = 2'd1,
        FLUSH  = 2'd2
    } REQ_OP;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } COMMAND;

endpackage

// File: rtl/cam_front.sv
// Request sequencer in front of a CAM: one LOOKUP/INSERT/FLUSH at a time, live-entry tracking,
// stale-match masking and a registered valid/ready response.
module cam_front
    import cam_front_pkg::*;
#(
    parameter  int SIZE  = 8,
    localparam int IDX_W = $clog2(SIZE),
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  REQ_OP            req_op,
    input  logic [31:0]      req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_full,
    output logic [CNT_W-1:0] count,
    output logic             cam_enable,
    output COMMAND           cam_command,
    output logic [31:0]      cam_data,
    output logic [IDX_W-1:0] cam_write_idx,
    input  logic [IDX_W-1:0] cam_read_idx,
    input  logic             cam_hit
);

    typedef enum logic [2:0] {IDLE, LOOK, CHECK, WR, RESP} state_e;

    state_e           state_q, state_d;
    REQ_OP            op_q, op_d;
    logic [31:0]      key_q, key_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic             rsp_full_q, rsp_full_d;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

    // Live entries sit at 0..count-1, so any CAM match at or above count is stale.
    logic eff_hit;
    logic table_full;
    assign eff_hit    = cam_hit && (CNT_W'(cam_read_idx) < count_q);
    assign table_full = (count_q == CNT_W'(SIZE));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_valid) state_d = (req_op == FLUSH) ? RESP : LOOK;
            LOOK:  state_d = CHECK;
            CHECK: state_d = (op_q == INSERT && !eff_hit && !table_full) ? WR : RESP;
            WR:    state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        key_d      = key_q;
        count_d    = count_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_full_d = rsp_full_q;
        rsp_idx_d  = rsp_idx_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                op_d       = req_op;
                key_d      = req_data;
                rsp_hit_d  = 1'b0;
                rsp_full_d = 1'b0;
                rsp_idx_d  = '0;
                if (req_op == FLUSH) count_d = '0;
            end
            CHECK: begin
                if (eff_hit) begin
                    rsp_hit_d = 1'b1;
                    rsp_idx_d = cam_read_idx;
                end else if (op_q == INSERT && table_full) begin
                    rsp_full_d = 1'b1;
                end
            end
            WR: begin
                rsp_idx_d = count_q[IDX_W-1:0];
                count_d   = count_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q       <= LOOKUP;
            key_q      <= '0;
            count_q    <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_full_q <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            op_q       <= op_d;
            key_q      <= key_d;
            count_q    <= count_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_full_q <= rsp_full_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        rsp_valid   = (state_q == RESP);
        cam_enable  = (state_q == LOOK) || (state_q == WR);
        cam_command = (state_q == WR) ? WRITE : READ;
    end

    assign cam_data      = key_q;
    assign cam_write_idx = count_q[IDX_W-1:0];
    assign rsp_hit       = rsp_hit_q;
    assign rsp_full      = rsp_full_q;
    assign rsp_idx       = rsp_idx_q;
    assign count         = count_q;

endmodule

// File: tb/tb_cam_front.sv
// Bench for cam_front: SIZE=8 and SIZE=5 instances, each with a behavioural CAM, checked against
// a live-key-list reference model with directed and random request streams.
module tb_cam_front;
    import cam_front_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_valid [2];
    logic        rsp_ready [2];
    REQ_OP       req_op;
    logic [31:0] req_data;
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_hit   [2];
    logic        rsp_full  [2];
    logic [2:0]  rsp_idx   [2];
    logic [3:0]  count8;
    logic [2:0]  count5;
    logic        cam_enable    [2];
    COMMAND      cam_command   [2];
    logic [31:0] cam_data      [2];
    logic [2:0]  cam_write_idx [2];
    logic [2:0]  cam_read_idx  [2];
    logic        cam_hit       [2];

    cam_front #(.SIZE(8)) dut8 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_hit(rsp_hit[0]),
        .rsp_idx(rsp_idx[0]), .rsp_full(rsp_full[0]), .count(count8),
        .cam_enable(cam_enable[0]), .cam_command(cam_command[0]), .cam_data(cam_data[0]),
        .cam_write_idx(cam_write_idx[0]), .cam_read_idx(cam_read_idx[0]), .cam_hit(cam_hit[0])
    );

    cam_front #(.SIZE(5)) dut5 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_hit(rsp_hit[1]),
        .rsp_idx(rsp_idx[1]), .rsp_full(rsp_full[1]), .count(count5),
        .cam_enable(cam_enable[1]), .cam_command(cam_command[1]), .cam_data(cam_data[1]),
        .cam_write_idx(cam_write_idx[1]), .cam_read_idx(cam_read_idx[1]), .cam_hit(cam_hit[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int d);
        return (d == 0) ? {28'b0, count8} : {29'b0, count5};
    endfunction

    // Behavioural CAM: every entry always compares (uninitialised contents included), lowest index wins.
    int          sizes [2] = '{8, 5};
    logic [31:0] cmem [2][8];
    int          n_writes [2] = '{0, 0};
    logic [2:0]  last_widx [2];
    logic [31:0] last_wdata [2];

    always @(posedge clock) begin
        logic       f;
        logic [2:0] fi;
        for (int d = 0; d < 2; d++) begin
            if (cam_enable[d] === 1'b1 && cam_command[d] == WRITE) begin
                cmem[d][cam_write_idx[d]] = cam_data[d];
                n_writes[d]   = n_writes[d] + 1;
                last_widx[d]  = cam_write_idx[d];
                last_wdata[d] = cam_data[d];
            end
            if (cam_enable[d] === 1'b1 && cam_command[d] == READ) begin
                f  = 1'b0;
                fi = 3'd0;
                for (int i = sizes[d] - 1; i >= 0; i--)
                    if (cmem[d][i] == cam_data[d]) begin
                        f  = 1'b1;
                        fi = 3'(i);
                    end
                cam_hit[d]      <= f;
                cam_read_idx[d] <= fi;
            end else begin
                cam_hit[d]      <= 1'($urandom);
                cam_read_idx[d] <= 3'($urandom);
            end
        end
    end

    // Reference model: ordered list of live keys per instance.
    logic [31:0] keys [2][8];
    int          n_live [2] = '{0, 0};

    task automatic do_req(input int d, input REQ_OP op, input logic [31:0] key, input int stall);
        logic       e_hit, e_full, e_write;
        int         e_idx, e_lat, pos, lat, w0;
        logic       got;
        string      t;
        e_hit = 0; e_full = 0; e_write = 0; e_idx = 0; pos = -1;
        for (int i = n_live[d] - 1; i >= 0; i--) if (keys[d][i] == key) pos = i;
        case (op)
            FLUSH: begin n_live[d] = 0; e_lat = 1; end
            INSERT: begin
                e_lat = 3;
                if (pos >= 0) begin e_hit = 1; e_idx = pos; end
                else if (n_live[d] == sizes[d]) e_full = 1;
                else begin
                    e_idx = n_live[d]; keys[d][n_live[d]] = key;
                    n_live[d]++; e_lat = 4; e_write = 1;
                end
            end
            default: begin
                e_lat = 3;
                if (pos >= 0) begin e_hit = 1; e_idx = pos; end
            end
        endcase
        t  = $sformatf("d%0d %s 0x%0h", d, op.name(), key);
        w0 = n_writes[d];

        @(negedge clock);
        req_op = op; req_data = key; req_valid[d] = 1'b1;
        check({t, " req_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clock);
        #1 req_valid[d] = 1'b0;

        lat = 0; got = 0;
        while (!got && lat < 12) begin
            @(negedge clock);
            lat++;
            if (rsp_valid[d] === 1'b1) got = 1;
        end
        check({t, " latency"}, 32'(lat), 32'(e_lat));
        if (!got) return;

        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clock);
            check({t, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({t, " rsp_hit"},   32'(rsp_hit[d]),   32'(e_hit));
            check({t, " rsp_full"},  32'(rsp_full[d]),  32'(e_full));
            check({t, " rsp_idx"},   32'(rsp_idx[d]),   32'(e_idx));
            check({t, " count"},     cnt_of(d),         32'(n_live[d]));
            if (s > 0) begin
                check({t, " stall req_ready"},  32'(req_ready[d]),  32'd0);
                check({t, " stall cam_enable"}, 32'(cam_enable[d]), 32'd0);
            end
        end
        check({t, " writes"}, 32'(n_writes[d] - w0), 32'(e_write));
        if (e_write) begin
            check({t, " write idx"},  32'(last_widx[d]), 32'(e_idx));
            check({t, " write data"}, last_wdata[d],     key);
        end

        rsp_ready[d] = 1'b1;
        @(posedge clock);
        #1 rsp_ready[d] = 1'b0;
        check({t, " post rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({t, " post req_ready"}, 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) cmem[d][i] = $urandom | 32'h8000_0000;
        cmem[0][0] = 32'h0;
        cmem[1][2] = 32'h0;
        req_op = LOOKUP; req_data = '0;
        req_valid = '{1'b0, 1'b0};
        rsp_ready = '{1'b0, 1'b0};
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset count",      cnt_of(d),             32'd0);
            check("reset rsp_valid",  32'(rsp_valid[d]),     32'd0);
            check("reset cam_enable", 32'(cam_enable[d]),    32'd0);
            check("reset rsp_hit",    32'(rsp_hit[d]),       32'd0);
            check("reset rsp_idx",    32'(rsp_idx[d]),       32'd0);
        end
        @(negedge clock) reset = 1'b0;
        check("reset req_ready", 32'(req_ready[0]), 32'd1);

        // Uninitialised entries that match must read as misses.
        do_req(0, LOOKUP, 32'h0, 0);
        do_req(1, LOOKUP, 32'h0, 0);

        do_req(0, INSERT, 32'hA, 0);
        do_req(0, INSERT, 32'hB, 0);
        do_req(0, INSERT, 32'hC, 0);
        do_req(0, LOOKUP, 32'hB, 0);
        do_req(0, INSERT, 32'hB, 1);
        for (int i = 0; i < 5; i++) do_req(0, INSERT, 32'h100 + 32'(i), 0);
        do_req(0, INSERT, 32'hFF, 0);
        do_req(0, LOOKUP, 32'h102, 5);

        do_req(0, FLUSH,  32'hDEAD, 0);
        do_req(0, LOOKUP, 32'hA, 0);
        do_req(0, INSERT, 32'hD, 0);
        do_req(0, LOOKUP, 32'hA, 0);

        for (int i = 0; i < 5; i++) do_req(1, INSERT, 32'h200 + 32'(i), 0);
        do_req(1, INSERT, 32'hFF, 2);
        do_req(1, LOOKUP, 32'h204, 0);

        for (int n = 0; n < 120; n++) begin
            int    d, r;
            REQ_OP op;
            d  = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 99));
            op = (r < 8) ? FLUSH : (r < 55) ? INSERT : LOOKUP;
            do_req(d, op, 32'($urandom_range(0, 11)), int'($urandom_range(0, 2)));
        end

        // Abort an insert while it is in its write cycle.
        do_req(0, FLUSH, 32'h0, 0);
        @(negedge clock);
        req_op = INSERT; req_data = 32'h5555_0000; req_valid[0] = 1'b1;
        @(posedge clock);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        check("wr cam_enable", 32'(cam_enable[0]), 32'd1);
        check("wr cam_command", 32'(cam_command[0]), 32'(WRITE));
        w0 = n_writes[0];
        #1 reset = 1'b1;
        #1 check("abort cam_enable", 32'(cam_enable[0]), 32'd0);
        repeat (2) @(negedge clock);
        check("abort writes",    32'(n_writes[0] - w0), 32'd0);
        check("abort count8",    cnt_of(0),             32'd0);
        check("abort count5",    cnt_of(1),             32'd0);
        check("abort rsp_valid", 32'(rsp_valid[0]),     32'd0);
        reset = 1'b0;
        n_live = '{0, 0};
        do_req(0, LOOKUP, 32'h5555_0000, 0);
        do_req(0, INSERT, 32'h5555_0000, 0);
        do_req(1, LOOKUP, 32'h204, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
